// File: rtl/arch_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : arch_pkg                                                     |
// | Description : Shared op/state encodings and default width for iter_divider |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package arch_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/iter_divider_if.sv
// +----------------------------------------------------------------------------+
// | Module      : iter_divider_if                                              |
// | Description : start/busy/done handshake and operand/result bundle          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

interface iter_divider_if
    import arch_pkg::*;
#(
    parameter int N = XLEN
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         flush;
    logic         busy;
    logic         done;
    logic [N-1:0] Y;

    modport master (
        output start, op, A, B, flush,
        input  busy, done, Y
    );

    modport slave (
        input  start, op, A, B, flush,
        output busy, done, Y
    );
endinterface

`default_nettype wire

// File: rtl/iter_divider_div_step.sv
// +----------------------------------------------------------------------------+
// | Module      : div_step                                                     |
// | Description : One combinational restoring-division step                    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module div_step #(
    parameter int N = 32
) (
    input  wire logic [N-1:0] rem_in,
    input  wire logic         dvd_bit,
    input  wire logic [N-1:0] divisor,
    output logic      [N-1:0] rem_out,
    output logic              q_bit
);
    logic [N:0]   w_shift;
    logic [N+1:0] w_diff;

    // Two guard bits: the shifted remainder can use all N+1 bits before the subtract.
    assign w_shift = {rem_in, dvd_bit};
    assign w_diff  = {1'b0, w_shift} - {2'b00, divisor};
    assign q_bit   = ~w_diff[N+1];
    assign rem_out = q_bit ? w_diff[N-1:0] : w_shift[N-1:0];

endmodule

`default_nettype wire

// File: rtl/iter_divider.sv
// +----------------------------------------------------------------------------+
// | Module      : iter_divider                                                 |
// | Description : Iterative restoring divider for DIV/DIVU/REM/REMU            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module iter_divider
    import arch_pkg::*;
#(
    parameter int N = XLEN
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    iter_divider_if.slave bus
);
    localparam int           CW      = $clog2(N);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);
    localparam logic [N-1:0] C_MIN   = {1'b1, {(N-1){1'b0}}};

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_div;
    logic [1:0]    r_op;
    logic          r_neg_q;
    logic          r_neg_r;
    logic [N-1:0]  r_y;

    logic          w_accept;
    logic          w_fast;
    logic [N-1:0]  w_fast_y;
    logic          w_signed;
    logic          w_b_zero;
    logic          w_ovf;
    logic [N-1:0]  w_a_abs;
    logic [N-1:0]  w_b_abs;
    logic [N-1:0]  w_rem_nxt;
    logic          w_qbit;
    logic [N-1:0]  w_q_final;
    logic [N-1:0]  w_result;

    div_step #(.N(N)) u_step (
        .rem_in  (r_rem),
        .dvd_bit (r_quot[N-1]),
        .divisor (r_div),
        .rem_out (w_rem_nxt),
        .q_bit   (w_qbit)
    );

    always_comb begin
        w_signed = ~bus.op[0];
        w_b_zero = (bus.B == '0);
        w_ovf    = w_signed && (bus.A == C_MIN) && (bus.B == '1);
        w_fast   = w_b_zero | w_ovf;
        w_a_abs  = (w_signed && bus.A[N-1]) ? -bus.A : bus.A;
        w_b_abs  = (w_signed && bus.B[N-1]) ? -bus.B : bus.B;
        if (w_b_zero)
            w_fast_y = bus.op[1] ? bus.A : '1;
        else
            w_fast_y = bus.op[1] ? '0 : bus.A;
    end

    // Shift register holds the unconsumed dividend in its high bits and the quotient below.
    always_comb begin
        w_q_final = {r_quot[N-2:0], w_qbit};
        if (r_op[1])
            w_result = r_neg_r ? -w_rem_nxt : w_rem_nxt;
        else
            w_result = r_neg_q ? -w_q_final : w_q_final;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (bus.start && !bus.flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (bus.flush)
                    w_state_nxt = S_IDLE;
                else if (r_count == C_LAST)
                    w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_op    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_y     <= '0;
        end else if (w_accept) begin
            r_op    <= bus.op;
            r_neg_q <= w_signed & (bus.A[N-1] ^ bus.B[N-1]);
            r_neg_r <= w_signed & bus.A[N-1];
            r_quot  <= w_a_abs;
            r_rem   <= '0;
            r_div   <= w_b_abs;
            r_count <= '0;
            if (w_fast)
                r_y <= w_fast_y;
        end else if (r_state == S_CALC && !bus.flush) begin
            r_quot  <= w_q_final;
            r_rem   <= w_rem_nxt;
            r_count <= r_count + 1'b1;
            if (r_count == C_LAST)
                r_y <= w_result;
        end
    end

    assign bus.busy = (r_state == S_CALC);
    assign bus.done = (r_state == S_DONE);
    assign bus.Y    = r_y;

endmodule

`default_nettype wire

// File: tb/tb_iter_divider.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_iter_divider                                              |
// | Description : Directed self-checking bench for iter_divider                |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_iter_divider;
    import arch_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    iter_divider_if #(.N(32)) intf ();

    iter_divider #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        intf.start = 1'b1;
        intf.op    = op;
        intf.A     = a;
        intf.B     = b;
    endtask

    // Returns at the negedge of the done cycle; lat counts cycles after the start cycle.
    task automatic wait_done(output int lat, output int nbusy);
        bit found;
        found = 1'b0;
        lat   = 0;
        nbusy = 0;
        while (!found && lat < 60) begin
            @(posedge clk);
            #1;
            intf.start = 1'b0;
            lat++;
            @(negedge clk);
            if (intf.done)
                found = 1'b1;
            else if (intf.busy)
                nbusy++;
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: no done within %0d cycles", lat);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_y, input int exp_lat);
        int lat;
        int nbusy;
        issue(op, a, b);
        wait_done(lat, nbusy);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, nbusy, exp_lat - 1);
        check({tag, "_y"}, intf.Y, exp_y);
    endtask

    initial begin
        int lat;
        int nbusy;
        int ndone;
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        intf.start = 1'b0;
        intf.op    = OP_DIV;
        intf.A     = '0;
        intf.B     = '0;
        intf.flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", intf.busy, 0);
        check("rst_done", intf.done, 0);
        check("rst_y", intf.Y, 0);
        rst_n = 1'b1;

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

        // Flush mid-calculation: result must keep the previous value.
        issue(OP_DIVU, 32'd1000, 32'd3);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            intf.start = 1'b0;
        end
        check("flush_busy_before", intf.busy, 1);
        intf.flush = 1'b1;
        @(posedge clk);
        #1;
        intf.flush = 1'b0;
        check("flush_busy_after", intf.busy, 0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (intf.done) ndone++;
        end
        check("flush_no_done", ndone, 0);
        check("flush_y_held", intf.Y, 32'd14);

        // Asynchronous reset mid-calculation.
        issue(OP_DIVU, 32'd1000, 32'd3);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            intf.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("arst_busy", intf.busy, 0);
        check("arst_done", intf.done, 0);
        check("arst_y", intf.Y, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (intf.done) ndone++;
        end
        check("arst_no_done", ndone, 0);

        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);

        run_op("divu_b0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_b0", OP_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // start held through CALC with different operands must be ignored.
        issue(OP_DIVU, 32'd100, 32'd7);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            intf.A = 32'd50;
            intf.B = 32'd5;
        end
        wait_done(lat, nbusy);
        check("hold_lat", lat + 20, 33);
        check("hold_y", intf.Y, 32'd14);

        // Back-to-back: second start raised inside the first done cycle.
        run_op("b2b_first", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        intf.start = 1'b1;
        intf.op    = OP_DIVU;
        intf.A     = 32'd9;
        intf.B     = 32'd3;
        @(posedge clk);
        #1;
        intf.start = 1'b0;
        check("b2b_no_idle", intf.busy, 1);
        lat = 1;
        while (!intf.done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_lat", lat, 33);
        check("b2b_y", intf.Y, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
